// File: rtl/led_blink_scheduler_if.sv
// rtl/led_blink_scheduler_if.sv - Requester/LED bundle between user logic and led_blink_scheduler.
// master = user logic raising requests, slave = the scheduler.
interface led_blink_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] rate;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic [N_REQ-1:0]   HW_led;

  modport master (output req, rate, input grant, busy, HW_led);
  modport slave  (input req, rate, output grant, busy, HW_led);
endinterface

// File: rtl/led_blink_scheduler.sv
// rtl/led_blink_scheduler.sv - Time-slotted sharing of the LED bank among blink requesters.
// Round-robin by default; define LED_SCHED_PRIO_EN for fixed lowest-index priority.
module led_blink_scheduler #(
  parameter int N_REQ      = 4,
  parameter int TICK_DIV   = 4,
  parameter int SLOT_TICKS = 16
) (
  input logic              clk,
  input logic              rst_n,
  led_blink_scheduler_if.slave bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SLOT_TICKS > 2) ? $clog2(SLOT_TICKS) : 1;
  localparam int IW = $clog2(N_REQ);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(SLOT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SERVE, GAP} state_t;

  state_t          state;
  logic [PW-1:0]   pre;
  logic            tick;
  logic [SW-1:0]   slot;
  logic [3:0]      phase;
  logic [1:0]      rate_l;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic [1:0]      win_rate;
  logic            any_req;
  logic            blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = (pre == PRE_MAX);

`ifdef LED_SCHED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) win = IW'(i);
    end
  end
`else
  // Scan backwards so the candidate closest after 'last' is written last and wins.
  always_comb begin
    logic [IW-1:0] idx;
    win = '0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (bus.req[idx]) win = idx;
    end
  end
`endif

  assign any_req  = |bus.req;
  assign win_rate = bus.rate[{win, 1'b0} +: 2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus.grant <= '0;
      bus.busy  <= 1'b0;
      slot      <= '0;
      phase     <= '0;
      rate_l    <= '0;
      last      <= IW'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.grant <= N_REQ'(1) << win;
            bus.busy  <= 1'b1;
            rate_l    <= win_rate;
            slot      <= '0;
            phase     <= '0;
            last      <= win;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (tick) begin
            phase <= phase + 1'b1;
            slot  <= slot + 1'b1;
            // 'last' holds the current owner for the whole slot.
            if (slot == SLOT_MAX || !bus.req[last]) begin
              bus.grant <= '0;
              state     <= GAP;
            end
          end
        end
        GAP: begin
          if (tick) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign blink      = phase[rate_l];
  assign bus.HW_led = bus.grant & {N_REQ{blink}};
endmodule
